seq_frame_tx: RTL and testbench

Serial frame transmitter that drives the line decoded by the 0110 sequence detector. Each accepted data word is sent as one frame on a single-bit line:
- 4-bit sync pattern 0110,
- DATA_W data bits, MSB first,
- optional even-parity bit,
- GAP_BITS stop bits of 1.

The idle line is 1, so it never contains the sync pattern. Bit slots advance only on a bit-rate enable, so one block serves any line rate.

---
 rtl/seq_frame_tx.sv | 152 +++++++++++++++
 tb/tb_seq_frame_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync 0110, DATA_W payload bits MSB first,
// optional even-parity bit, GAP_BITS stop bits of 1. The line idles at 1,
// and every bit slot advances only on clock edges qualified by bit_en.
module seq_frame_tx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int GAP_BITS  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bit_en,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              x_out,
  output logic              busy,
  output logic              frame_start,
  output logic              done
);

  // The slot counter is shared by SYNC, DATA and STOP, so it is sized for
  // the longest of the three phases.
  localparam int MAX_SYNC = 4;
  localparam int MAX_DG   = (DATA_W > GAP_BITS) ? DATA_W : GAP_BITS;
  localparam int MAX_CNT  = (MAX_DG > MAX_SYNC) ? MAX_DG : MAX_SYNC;
  localparam int CNT_W    = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(MAX_SYNC - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(GAP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_sh;
  logic              r_par;
  logic              r_x;
  logic              r_busy;
  logic              r_fs;
  logic              r_done;
  logic              w_accept;

  // Even parity: the parity bit makes the total number of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

  // Line level for a given sync slot: 0,1,1,0.
  function automatic logic sync_bit(input logic [CNT_W-1:0] slot);
    return (slot == CNT_W'(1)) || (slot == CNT_W'(2));
  endfunction

  assign din_ready   = (r_state == S_IDLE) & bit_en;
  assign w_accept    = din_ready & din_valid;
  assign x_out       = r_x;
  assign busy        = r_busy;
  assign frame_start = r_fs;
  assign done        = r_done;

  // Frame FSM: walks the slots on bit_en edges; the strobes are one-cycle pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_par   <= 1'b0;
      r_x     <= 1'b1;
      r_busy  <= 1'b0;
      r_fs    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_fs   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sh    <= din;
            r_par   <= even_parity(din);
            r_cnt   <= '0;
            r_x     <= sync_bit('0);
            r_busy  <= 1'b1;
            r_fs    <= 1'b1;
            r_state <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (bit_en) begin
            if (r_cnt == SYNC_LAST) begin
              r_cnt   <= '0;
              r_x     <= r_sh[DATA_W-1];
              r_sh    <= r_sh << 1;
              r_state <= S_DATA;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              r_x   <= sync_bit(r_cnt + CNT_W'(1));
            end
          end
        end
        S_DATA: begin
          if (bit_en) begin
            if (r_cnt == DATA_LAST) begin
              r_cnt <= '0;
              if (PARITY_EN != 0) begin
                r_x     <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_x     <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              r_x   <= r_sh[DATA_W-1];
              r_sh  <= r_sh << 1;
            end
          end
        end
        S_PARITY: begin
          if (bit_en) begin
            r_cnt   <= '0;
            r_x     <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_en) begin
            if (r_cnt == STOP_LAST) begin
              r_cnt   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_x     <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx at default parameters.
module tb_seq_frame_tx;

  localparam int DATA_W    = 8;
  localparam int PARITY_EN = 1;
  localparam int GAP_BITS  = 2;
  localparam int L         = 4 + DATA_W + PARITY_EN + GAP_BITS;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              bit_en = 1'b0;
  logic              din_valid = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              din_ready;
  logic              x_out;
  logic              busy;
  logic              frame_start;
  logic              done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  typedef struct {
    logic [DATA_W-1:0] din;
    int                mode;
    logic [L-1:0]      frame;
  } vec_t;

  vec_t tbl[6];

  seq_frame_tx #(
    .DATA_W(DATA_W),
    .PARITY_EN(PARITY_EN),
    .GAP_BITS(GAP_BITS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bit_en(bit_en),
    .din(din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .x_out(x_out),
    .busy(busy),
    .frame_start(frame_start),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected frame as a bit list, first transmitted bit in the MSB.
  function automatic logic [L-1:0] model_frame(input logic [DATA_W-1:0] w);
    logic q[$];
    logic [L-1:0] f;
    q.push_back(1'b0);
    q.push_back(1'b1);
    q.push_back(1'b1);
    q.push_back(1'b0);
    for (int i = DATA_W - 1; i >= 0; i--) q.push_back(w[i]);
    if (PARITY_EN != 0) q.push_back(($countones(w) % 2) == 1);
    for (int i = 0; i < GAP_BITS; i++) q.push_back(1'b1);
    for (int i = 0; i < L; i++) f[L-1-i] = q[i];
    return f;
  endfunction

  // Bit-enable pattern: 0 = always on, 1 = alternate starting off, 2 = random.
  function automatic logic pick(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 2) == 0;
    return $urandom_range(0, 2) != 0;
  endfunction

  // Sends one word from an idle DUT and follows it slot by slot to done.
  task automatic run_frame(input logic [DATA_W-1:0] w, input int mode,
                           input logic [L-1:0] exp_f, input string tag);
    int   slot;
    int   k;
    int   wait_n;
    logic en_prev;
    bit   fin;
    din       = w;
    din_valid = 1'b1;
    bit_en    = (mode == 2) ? pick(2, 0) : 1'b1;
    wait_n    = 0;
    while (!bit_en) begin
      step();
      chk($sformatf("%s no-accept busy", tag), busy, 0);
      chk($sformatf("%s no-accept x", tag), x_out, 1);
      wait_n++;
      bit_en = (wait_n > 20) ? 1'b1 : pick(2, 0);
    end
    step();
    acc_cyc   = cyc;
    din_valid = 1'b0;
    din       = DATA_W'($urandom);
    chk($sformatf("%s frame_start", tag), frame_start, 1);
    chk($sformatf("%s busy at accept", tag), busy, 1);
    chk($sformatf("%s done at accept", tag), done, 0);
    chk($sformatf("%s x slot0", tag), x_out, exp_f[L-1]);
    slot = 0;
    k    = 1;
    fin  = 1'b0;
    while (!fin && k < 2000) begin
      bit_en  = pick(mode, k);
      en_prev = bit_en;
      step();
      k++;
      if (en_prev) slot++;
      if (slot < L) begin
        chk($sformatf("%s x slot%0d", tag, slot), x_out, exp_f[L-1-slot]);
        chk($sformatf("%s busy slot%0d", tag, slot), busy, 1);
        chk($sformatf("%s done slot%0d", tag, slot), done, 0);
        chk($sformatf("%s frame_start slot%0d", tag, slot), frame_start, 0);
      end else begin
        fin = 1'b1;
        chk($sformatf("%s done pulse", tag), done, 1);
        chk($sformatf("%s busy at end", tag), busy, 0);
        chk($sformatf("%s x at end", tag), x_out, 1);
        if (mode == 0) chk($sformatf("%s done cycle", tag), k, L + 1);
        if (mode == 1) chk($sformatf("%s done cycle gated", tag), k, 2 * L + 1);
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no done, expected done within 2000 cycles", tag);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    int                a1;
    logic              xs[64];
    logic              fss[64];
    int                zpos[$];

    tbl[0] = '{8'hA5, 0, 15'b0110_10100101_0_11};
    tbl[1] = '{8'h3C, 1, 15'b0110_00111100_0_11};
    tbl[2] = '{8'hFF, 0, 15'b0110_11111111_0_11};
    tbl[3] = '{8'h00, 2, 15'b0110_00000000_0_11};
    tbl[4] = '{8'h01, 0, 15'b0110_00000001_1_11};
    tbl[5] = '{8'h80, 1, 15'b0110_10000000_1_11};

    // Reset values
    reset_n   = 1'b0;
    bit_en    = 1'b1;
    din_valid = 1'b0;
    repeat (3) step();
    chk("rst x_out", x_out, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst frame_start", frame_start, 0);
    chk("rst din_ready", din_ready, 1);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("idle%0d x_out", i), x_out, 1);
      chk($sformatf("idle%0d busy", i), busy, 0);
      chk($sformatf("idle%0d frame_start", i), frame_start, 0);
      chk($sformatf("idle%0d done", i), done, 0);
    end

    // Valid without bit_en: nothing may happen
    bit_en = 1'b0;
    #1;
    chk("din_ready bit_en=0", din_ready, 0);
    din_valid = 1'b1;
    din       = 8'h55;
    repeat (4) step();
    chk("valid no bit_en busy", busy, 0);
    chk("valid no bit_en fs", frame_start, 0);
    chk("valid no bit_en x", x_out, 1);
    din_valid = 1'b0;
    bit_en    = 1'b1;
    step();
    chk("valid dropped busy", busy, 0);
    chk("din_ready idle", din_ready, 1);

    // Table of known frames under several bit_en patterns
    for (int i = 0; i < 6; i++)
      run_frame(tbl[i].din, tbl[i].mode, tbl[i].frame, $sformatf("tbl%0d", i));

    // Back-to-back frames: valid presented right after done
    run_frame(8'h3C, 0, tbl[1].frame, "b2b0");
    a1 = acc_cyc;
    run_frame(8'hFF, 0, tbl[2].frame, "b2b1");
    chk("b2b accept spacing", acc_cyc - a1, L + 1);

    // Asynchronous abort in the middle of the data phase
    din       = 8'hA5;
    din_valid = 1'b1;
    bit_en    = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (6) step();
    chk("abort pre busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort x_out", x_out, 1);
    chk("abort busy", busy, 0);
    chk("abort frame_start", frame_start, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("abort hold%0d done", i), done, 0);
      chk($sformatf("abort hold%0d x", i), x_out, 1);
    end
    reset_n = 1'b1;
    step();
    chk("abort release done", done, 0);
    run_frame(8'hA5, 0, tbl[0].frame, "post-abort");

    // Randomised words against the reference frame model
    for (int i = 0; i < 25; i++) begin
      w = DATA_W'($urandom);
      run_frame(w, i % 3, model_frame(w), $sformatf("rnd%0d", i));
    end

    // Loopback: 0110 detection on the line stream over three zero frames
    step();
    din       = '0;
    din_valid = 1'b1;
    bit_en    = 1'b1;
    for (int i = 0; i < 52; i++) begin
      step();
      xs[i]  = x_out;
      fss[i] = frame_start;
      if (i == 2 * (L + 1)) din_valid = 1'b0;
    end
    for (int i = 3; i < 52; i++)
      if ({xs[i-3], xs[i-2], xs[i-1], xs[i]} == 4'b0110) zpos.push_back(i);
    chk("loopback z count", zpos.size(), 3);
    for (int n = 0; n < zpos.size() && n < 3; n++) begin
      chk($sformatf("loopback z%0d position", n), zpos[n], 3 + n * (L + 1));
      chk($sformatf("loopback z%0d sync start", n), fss[zpos[n]-3], 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
